// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam int OP_LSB    = 26;
  localparam int FUNCT_LSB = 20;
  localparam int RD_LSB    = 12;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO; push and pop in one cycle are both applied, flush empties it.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is data only; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues imem requests, queues returned words for decode.
import fetch_pkg::*;

module fetch_unit #(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [1:0]      id_op,
  output logic [5:0]      id_funct,
  output logic [3:0]      id_rd
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt, hold_addr;
  logic            hold_q, hold_nxt, pend_q, pend_nxt;
  logic [CW-1:0]   discard, discard_nxt, out_nxt;
  logic [CW-1:0]   q_count, pc_count;
  logic            q_full, q_empty, pc_full, pc_empty;
  logic [2*XLEN-1:0] q_head;
  logic [XLEN-1:0] pc_head;
  logic [CW:0]     occ;
  logic            pop, fire, drop, push, issue_ok;

  always_comb begin
    pop       = ~q_empty & instr_ready;
    // A same-cycle pop frees a slot so zero-wait memory sustains one fetch per cycle.
    occ       = {1'b0, pc_count} + {1'b0, q_count} - (CW+1)'(pop);
    issue_ok  = (state == RUN) & (pend_q | (occ < (CW+1)'(DEPTH)));
    imem_req  = hold_q | issue_ok;
    imem_addr = hold_q ? hold_addr : fetch_pc;
    fire      = imem_req & imem_gnt;
    drop      = imem_rvalid & (redirect_valid | (discard != '0));
    push      = imem_rvalid & ~drop;
    out_nxt   = pc_count + CW'(fire) - CW'(imem_rvalid);
  end

  always_comb begin
    discard_nxt  = discard;
    fetch_pc_nxt = fetch_pc;
    hold_nxt     = hold_q ? ~imem_gnt : (redirect_valid & imem_req & ~imem_gnt);
    pend_nxt     = ~hold_q & imem_req & ~imem_gnt & ~redirect_valid;
    state_nxt    = state;
    if (fire && !hold_q) fetch_pc_nxt = fetch_pc + XLEN'(4);
    // A stale request held across a redirect is discarded once it is finally granted.
    if (redirect_valid) begin
      discard_nxt  = out_nxt;
      fetch_pc_nxt = redirect_pc;
    end else begin
      discard_nxt = discard - CW'(imem_rvalid & (discard != '0)) + CW'(fire & hold_q);
    end
    unique case (state)
      BOOT:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      FLUSH:   state_nxt = (discard_nxt == '0) ? RUN : FLUSH;
      default: state_nxt = BOOT;
    endcase
    if (redirect_valid) state_nxt = (discard_nxt != '0) ? FLUSH : RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      discard  <= '0;
      hold_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      discard  <= discard_nxt;
      hold_q   <= hold_nxt;
      pend_q   <= pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!hold_q && redirect_valid && imem_req && !imem_gnt) hold_addr <= fetch_pc;
  end

  fetch_fifo #(.DEPTH(DEPTH), .W(XLEN)) u_pc_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fire),
    .din   (imem_addr),
    .pop   (imem_rvalid),
    .flush (1'b0),
    .dout  (pc_head),
    .count (pc_count),
    .full  (pc_full),
    .empty (pc_empty)
  );

  fetch_fifo #(.DEPTH(DEPTH), .W(2*XLEN)) u_instr_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({imem_rdata, pc_head}),
    .pop   (pop),
    .flush (redirect_valid),
    .dout  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign instr_valid = ~q_empty;
  assign instr       = instr_valid ? q_head[2*XLEN-1:XLEN] : '0;
  assign instr_pc    = instr_valid ? q_head[XLEN-1:0] : '0;
  assign id_op       = instr[OP_LSB +: 2];
  assign id_funct    = instr[FUNCT_LSB +: 6];
  assign id_rd       = instr[RD_LSB +: 4];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && q_full && (discard == '0)));
  a_pc_tracked: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && pc_empty));
  a_pc_room: assert property (@(posedge clk) disable iff (!rst_n)
    !(fire && pc_full && !imem_rvalid));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit with a one-cycle-latency memory model.
module tb_fetch_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req, imem_gnt, imem_rvalid;
  logic [XLEN-1:0] imem_addr, imem_rdata;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            instr_valid, instr_ready = 1'b0;
  logic [XLEN-1:0] instr, instr_pc;
  logic [1:0]      id_op;
  logic [5:0]      id_funct;
  logic [3:0]      id_rd;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .id_op          (id_op),
    .id_funct       (id_funct),
    .id_rd          (id_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h0101_0101) ^ 32'hE281_1001;
  endfunction

  // Memory: grants while under the grant limit, answers one cycle after each grant.
  int limit = 0;
  int granted;
  assign imem_gnt = (granted < limit);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      granted     <= 0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end else begin
      imem_rvalid <= imem_req && imem_gnt;
      imem_rdata  <= memf(imem_addr);
      if (imem_req && imem_gnt) granted <= granted + 1;
    end
  end

  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_req, last_req, first_pop, last_pop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    logic [31:0] e, d;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (imem_req && imem_gnt) begin
          if (exp_addr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: got addr %h, none expected", imem_addr);
          end else begin
            e = exp_addr.pop_front();
            chk("req_addr", imem_addr, e);
          end
          if (first_req < 0) first_req = cyc;
          last_req = cyc;
        end
        if (instr_valid && instr_ready) begin
          if (exp_pc.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_instr: got pc %h, none expected", instr_pc);
          end else begin
            e = exp_pc.pop_front();
            d = memf(e);
            chk("instr_pc", instr_pc, e);
            chk("instr", instr, d);
            chk("id_op", {30'b0, id_op}, {30'b0, d[27:26]});
            chk("id_funct", {26'b0, id_funct}, {26'b0, d[25:20]});
            chk("id_rd", {28'b0, id_rd}, {28'b0, d[15:12]});
          end
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
        end
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench in the BOOT cycle right after reset release.
  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    limit = 0;
    #1;
    exp_addr.delete();
    exp_pc.delete();
    first_req = -1; last_req = -1; first_pop = -1; last_pop = -1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && (exp_addr.size() + exp_pc.size()) != 0; i++) step(1);
    step(3);
    chk(name, exp_addr.size() + exp_pc.size(), 0);
  endtask

  task automatic wait_granted(input int n);
    for (int i = 0; i < 40 && granted != n; i++) step(1);
    chk("wait_granted", granted, n);
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    // Reset state
    rst_n = 1'b0;
    #12;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_id", {id_op, id_funct, id_rd}, 0);

    // Streaming with zero-wait memory
    do_reset();
    for (int i = 0; i < 6; i++) begin
      exp_addr.push_back(32'(i * 4));
      exp_pc.push_back(32'(i * 4));
    end
    limit = 6;
    instr_ready = 1'b1;
    drain("drain_stream");
    chk("req_span", last_req - first_req, 5);
    chk("pop_latency", first_pop - first_req, 2);
    chk("pop_span", last_pop - first_pop, 5);

    // Decode stalled: only DEPTH fetches in flight/queued
    do_reset();
    foreach (exp_addr[i]) exp_addr.delete(i);
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(32'(i * 4));
      exp_pc.push_back(32'(i * 4));
    end
    limit = 4;
    step(6);
    chk("stall_granted", granted, 2);
    chk("stall_req", imem_req, 0);
    chk("stall_valid", instr_valid, 1);
    chk("stall_instr", instr, 32'hE281_1001);
    chk("stall_pc", instr_pc, 32'h0);
    chk("stall_op", {30'b0, id_op}, 32'h0);
    chk("stall_funct", {26'b0, id_funct}, 32'h28);
    chk("stall_rd", {28'b0, id_rd}, 32'h1);
    instr_ready = 1'b1;
    drain("drain_stall");

    // Held request across a redirect
    do_reset();
    exp_addr.push_back(32'h0);  exp_addr.push_back(32'h4);  exp_addr.push_back(32'h8);
    exp_addr.push_back(32'h40); exp_addr.push_back(32'h44);
    exp_pc.push_back(32'h0);  exp_pc.push_back(32'h4);
    exp_pc.push_back(32'h40); exp_pc.push_back(32'h44);
    instr_ready = 1'b1;
    limit = 2;
    wait_granted(2);
    chk("hold1_req", imem_req, 1);
    chk("hold1_addr", imem_addr, 32'h8);
    step(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    chk("hold2_addr", imem_addr, 32'h8);
    step(1);
    redirect_valid = 1'b0;
    chk("hold3_req", imem_req, 1);
    chk("hold3_addr", imem_addr, 32'h8);
    step(1);
    limit = 5;
    drain("drain_hold");

    // Redirect colliding with rvalid of 12 and grant of 16
    do_reset();
    exp_addr.push_back(32'h0);  exp_addr.push_back(32'h4);  exp_addr.push_back(32'h8);
    exp_addr.push_back(32'hC);  exp_addr.push_back(32'h10);
    exp_addr.push_back(32'h80); exp_addr.push_back(32'h84);
    exp_pc.push_back(32'h0); exp_pc.push_back(32'h4); exp_pc.push_back(32'h8);
    exp_pc.push_back(32'h80); exp_pc.push_back(32'h84);
    instr_ready = 1'b1;
    limit = 7;
    wait_granted(1);
    step(3);
    chk("coll_rvalid", imem_rvalid, 1);
    chk("coll_addr", imem_addr, 32'h10);
    chk("coll_fire", imem_req & imem_gnt, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    step(1);
    redirect_valid = 1'b0;
    chk("flush_noreq", imem_req, 0);
    drain("drain_flush");

    // PC wrap at the top of the address space
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    exp_addr.push_back(32'hFFFF_FFFC); exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
    exp_pc.push_back(32'hFFFF_FFFC);   exp_pc.push_back(32'h0);   exp_pc.push_back(32'h4);
    instr_ready = 1'b1;
    limit = 3;
    step(1);
    redirect_valid = 1'b0;
    drain("drain_wrap");

    // Reset asserted with two entries queued
    do_reset();
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
    limit = 8;
    step(6);
    chk("pre_rst_valid", instr_valid, 1);
    chk("pre_rst_req", imem_req, 0);
    chk("pre_rst_pending", exp_addr.size(), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_req", imem_req, 0);
    do_reset();
    exp_addr.push_back(32'h0);
    exp_pc.push_back(32'h0);
    instr_ready = 1'b1;
    limit = 1;
    drain("drain_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
